capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
- Sample-memory capture controller; the consumer of the trigger's `trig_out`.
- Arms the trigger after a programmed pre-trigger fill and drives a circular write address into sample SRAM on every CLK_EN.
- On trigger, counts the post-trigger samples, then freezes the record and hands the memory to the MCU for sequential readout.
- Sits between the decimator (CLK_EN), the trigger block, and the SRAM/MCU bus.

Parameters:
- ADDR_W, 17, sample memory address width; depth = 2^ADDR_W.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- CLK_EN  in  1  sample strobe from decimator; one sample per high cycle.
- Start  in  1  MCU start pulse; starts or restarts a capture.
- Stop  in  1  MCU abort pulse.
- Pre_Len  in  ADDR_W  pre-trigger sample count.
- Post_Len  in  ADDR_W  post-trigger sample count.
- Trig_In  in  1  trigger event level (trigger's `trig_out`).
- Rd_Next  in  1  MCU read strobe; advance read address.
- Enable_Trig  out  1  arms trigger block (drives its Enable_Trig).
- Wr_En  out  1  SRAM write enable, qualified by CLK_EN.
- Mem_Addr  out  ADDR_W  SRAM address (write pointer while capturing, read pointer in DONE).
- Trig_Addr  out  ADDR_W  write address latched at trigger.
- Capture_Done  out  1  record complete and readable.

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters 0.
- All outputs are registered.
- States: IDLE, PRE_FILL, ARMED, POST, DONE.
- Length capture: Pre_Len and Post_Len are captured into internal registers on Start. Later changes have no effect until the next Start.
- IDLE:
  - Start -> PRE_FILL.
  - Wr addr <= 0; pre counter <= Pre_Len; Capture_Done <= 0.
- Write strobe:
  - Wr_En = CLK_EN & (state in PRE_FILL/ARMED/POST), registered alongside the Mem_Addr it writes.
  - Write address increments modulo 2^ADDR_W after each written sample; wrap is silent.
- PRE_FILL:
  - Each CLK_EN decrements the pre counter.
  - When the counter is 0 on a CLK_EN (Pre_Len=0 -> first CLK_EN) -> ARMED, and Enable_Trig <= 1 in the same edge.
- ARMED:
  - Trig_In is sampled every CLK cycle, not only on CLK_EN, because the trigger output lags CLK_EN by one cycle.
  - On the first cycle with Trig_In=1: Trig_Addr <= current write address; post counter <= latched Post_Len; -> POST.
  - Trig_In in any other state is ignored.
- POST:
  - Each CLK_EN writes a sample and decrements the counter.
  - On a CLK_EN with counter 0 (Post_Len=0 -> exactly one post sample): -> DONE.
  - In the same edge: Enable_Trig <= 0, Capture_Done <= 1, read pointer <= Trig_Addr - Pre_Len (mod 2^ADDR_W).
- DONE:
  - Wr_En held 0; Mem_Addr = read pointer.
  - Each Rd_Next cycle increments the read pointer (mod 2^ADDR_W). Rd_Next is ignored in other states.
  - Start -> restart as from IDLE.
- Stop in any state -> IDLE next edge:
  - Enable_Trig, Wr_En, Capture_Done <= 0.
  - Trig_Addr is retained.
  - Stop and Start in the same cycle: Stop wins.
- Start while PRE_FILL/ARMED/POST restarts the capture: address 0, Enable_Trig <= 0 for at least one cycle so the trigger clears its event registers.
- Pre_Len+Post_Len >= depth is not checked; the oldest samples are overwritten.

Optional Feature:
- Macro: CAPTURE_AUTO_TRIG_EN (scope AUTO mode).
- With it defined:
  - Adds input Auto_Len [15:0].
  - A timeout counter reloads on entry to ARMED and decrements on each CLK_EN.
  - At 0 it forces the ARMED->POST transition exactly as a trigger would, and sets output Auto_Fired <= 1 (cleared on Start/Stop/RST).
  - Auto_Len=0 disables the timeout.
- Without it: no port, no counter; ARMED waits indefinitely for Trig_In.

Decomposition:
- Shared package (`capture_pkg`):
  - state enum (IDLE=0, PRE_FILL=1, ARMED=2, POST=3, DONE=4), 3-bit encoding;
  - ADDR_W default constant.
- Sub-module `capture_len_cnt`: loadable down-counter with zero flag and CLK_EN decrement. Instantiated for pre and post counts (and the auto timeout when enabled).

Test Plan:
- Pre_Len=4, Post_Len=3, CLK_EN every cycle, Trig_In rises 10 cycles after arming:
  - Enable_Trig rises after 5th sample;
  - Trig_Addr = address at trigger;
  - Capture_Done after 4 further samples;
  - read pointer = Trig_Addr-4.
- CLK_EN 1-in-4, Trig_In asserted on a CLK_EN=0 cycle -> trigger still latched that cycle; POST counts only CLK_EN cycles.
- ADDR_W=4, Pre_Len=2, trigger after 20 samples -> write address wraps 15->0. Post_Len=0 -> exactly one post sample; read pointer wraps correctly.
- Stop asserted mid-POST -> IDLE next edge, Wr_En=0, Enable_Trig=0, Capture_Done stays 0. Start+Stop same cycle -> remains IDLE.
- In DONE, 5 Rd_Next pulses -> Mem_Addr = start+5. Trig_In toggling in DONE -> no state change.
- CAPTURE_AUTO_TRIG_EN, Auto_Len=8, no trigger -> POST entered on 9th CLK_EN after arming, Auto_Fired=1. RST asserted mid-ARMED clears all outputs asynchronously.

Source files
------------

// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for the capture controller: FSM state encoding and
// the default sample-memory address width.
package capture_pkg;

  localparam int ADDR_W_DEF = 17;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_FILL = 3'd1,
    ARMED    = 3'd2,
    POST     = 3'd3,
    DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/capture_ctrl_if.sv
// Bus bundle between the capture controller and its surroundings
// (decimator strobe, trigger block, SRAM and MCU).
// The macro CAPTURE_AUTO_TRIG_EN adds the auto-trigger timeout signals.
interface capture_ctrl_if import capture_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              CLK_EN;
  logic              Start;
  logic              Stop;
  logic [ADDR_W-1:0] Pre_Len;
  logic [ADDR_W-1:0] Post_Len;
  logic              Trig_In;
  logic              Rd_Next;
  logic              Enable_Trig;
  logic              Wr_En;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [ADDR_W-1:0] Trig_Addr;
  logic              Capture_Done;
`ifdef CAPTURE_AUTO_TRIG_EN
  logic [15:0]       Auto_Len;
  logic              Auto_Fired;
`endif

  // Environment side: drives strobes and lengths, observes the controller.
  modport master (
`ifdef CAPTURE_AUTO_TRIG_EN
    output Auto_Len,
    input  Auto_Fired,
`endif
    output CLK_EN, Start, Stop, Pre_Len, Post_Len, Trig_In, Rd_Next,
    input  Enable_Trig, Wr_En, Mem_Addr, Trig_Addr, Capture_Done
  );

  // Controller side.
  modport slave (
`ifdef CAPTURE_AUTO_TRIG_EN
    input  Auto_Len,
    output Auto_Fired,
`endif
    input  CLK_EN, Start, Stop, Pre_Len, Post_Len, Trig_In, Rd_Next,
    output Enable_Trig, Wr_En, Mem_Addr, Trig_Addr, Capture_Done
  );

endinterface

// File: rtl/capture_ctrl_len_cnt.sv
// capture_len_cnt: loadable down-counter with zero flag. Used for the
// pre-trigger fill, the post-trigger count and the auto-trigger timeout.
module capture_len_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement; the count parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: sample-memory capture controller. Fills a pre-trigger
// window, arms the trigger, counts post-trigger samples into a circular
// SRAM address space, then freezes the record for sequential MCU readout.
// Optional feature macro: CAPTURE_AUTO_TRIG_EN (auto-trigger timeout).
module capture_ctrl import capture_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic           CLK,
  input logic           RST,
  capture_ctrl_if.slave bus
);

  typedef logic [ADDR_W-1:0] addr_t;
  localparam addr_t ADDR_ONE = addr_t'(1);

  state_e state, state_nxt;
  addr_t  wr_addr, wr_addr_nxt;
  addr_t  rd_ptr, rd_ptr_nxt;
  addr_t  pre_len_q, pre_len_nxt;
  addr_t  post_len_q, post_len_nxt;
  addr_t  trig_addr_q, trig_addr_nxt;
  addr_t  mem_addr_q, mem_addr_nxt;
  logic   enable_trig_q, enable_trig_nxt;
  logic   wr_en_q, wr_en_nxt;
  logic   done_q, done_nxt;
  logic   pre_load, pre_dec, pre_zero;
  logic   post_load, post_dec, post_zero;
  logic   trig_hit;

  assign pre_dec  = bus.CLK_EN && (state == PRE_FILL);
  assign post_dec = bus.CLK_EN && (state == POST);

  capture_len_cnt #(.W(ADDR_W)) u_pre_cnt (
    .clk(CLK), .rst(RST), .load(pre_load), .load_val(bus.Pre_Len),
    .dec(pre_dec), .zero(pre_zero)
  );

  capture_len_cnt #(.W(ADDR_W)) u_post_cnt (
    .clk(CLK), .rst(RST), .load(post_load), .load_val(post_len_q),
    .dec(post_dec), .zero(post_zero)
  );

`ifdef CAPTURE_AUTO_TRIG_EN
  logic auto_load, auto_dec, auto_zero, auto_hit;
  logic auto_en_q, auto_en_nxt, auto_fired_q, auto_fired_nxt;

  assign auto_dec = bus.CLK_EN && (state == ARMED);
  // A zero Auto_Len at arming time leaves the timeout disabled.
  assign auto_hit = auto_dec && auto_zero && auto_en_q;
  assign trig_hit = bus.Trig_In || auto_hit;
  assign bus.Auto_Fired = auto_fired_q;

  capture_len_cnt #(.W(16)) u_auto_cnt (
    .clk(CLK), .rst(RST), .load(auto_load), .load_val(bus.Auto_Len),
    .dec(auto_dec), .zero(auto_zero)
  );
`else
  assign trig_hit = bus.Trig_In;
`endif

  // Next-state and next-output decode; Stop beats Start, Start beats the FSM.
  always_comb begin
    // NOTE: every target gets a default first so no latch is inferred.
    state_nxt       = state;
    wr_addr_nxt     = wr_addr;
    rd_ptr_nxt      = rd_ptr;
    pre_len_nxt     = pre_len_q;
    post_len_nxt    = post_len_q;
    trig_addr_nxt   = trig_addr_q;
    mem_addr_nxt    = mem_addr_q;
    enable_trig_nxt = enable_trig_q;
    wr_en_nxt       = 1'b0;
    done_nxt        = done_q;
    pre_load        = 1'b0;
    post_load       = 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
    auto_load       = 1'b0;
    auto_en_nxt     = auto_en_q;
    auto_fired_nxt  = auto_fired_q;
`endif
    if (bus.Stop) begin
      state_nxt       = IDLE;
      enable_trig_nxt = 1'b0;
      done_nxt        = 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
      auto_fired_nxt  = 1'b0;
`endif
    end else if (bus.Start) begin
      // Restart drops Enable_Trig so the trigger block clears its event state.
      state_nxt       = PRE_FILL;
      wr_addr_nxt     = '0;
      pre_load        = 1'b1;
      pre_len_nxt     = bus.Pre_Len;
      post_len_nxt    = bus.Post_Len;
      enable_trig_nxt = 1'b0;
      done_nxt        = 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
      auto_fired_nxt  = 1'b0;
`endif
    end else begin
      // Every strobe while capturing writes one sample at the current pointer.
      if (bus.CLK_EN && (state == PRE_FILL || state == ARMED || state == POST)) begin
        wr_en_nxt    = 1'b1;
        mem_addr_nxt = wr_addr;
        wr_addr_nxt  = wr_addr + ADDR_ONE;
      end
      case (state)
        IDLE: begin
          wr_addr_nxt = '0;
          pre_load    = 1'b1;
          done_nxt    = 1'b0;
        end
        PRE_FILL: begin
          if (bus.CLK_EN && pre_zero) begin
            state_nxt       = ARMED;
            enable_trig_nxt = 1'b1;
`ifdef CAPTURE_AUTO_TRIG_EN
            auto_load       = 1'b1;
            auto_en_nxt     = (bus.Auto_Len != 16'd0);
`endif
          end
        end
        ARMED: begin
          // Checked every clock: the trigger output lags the strobe by one cycle.
          if (trig_hit) begin
            state_nxt     = POST;
            trig_addr_nxt = wr_addr;
            post_load     = 1'b1;
`ifdef CAPTURE_AUTO_TRIG_EN
            if (!bus.Trig_In) auto_fired_nxt = 1'b1;
`endif
          end
        end
        POST: begin
          if (bus.CLK_EN && post_zero) begin
            state_nxt       = DONE;
            enable_trig_nxt = 1'b0;
            done_nxt        = 1'b1;
            rd_ptr_nxt      = trig_addr_q - pre_len_q;
          end
        end
        DONE: begin
          rd_ptr_nxt   = rd_ptr + addr_t'(bus.Rd_Next);
          mem_addr_nxt = rd_ptr + addr_t'(bus.Rd_Next);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      wr_addr       <= '0;
      rd_ptr        <= '0;
      pre_len_q     <= '0;
      post_len_q    <= '0;
      trig_addr_q   <= '0;
      mem_addr_q    <= '0;
      enable_trig_q <= 1'b0;
      wr_en_q       <= 1'b0;
      done_q        <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
      auto_en_q     <= 1'b0;
      auto_fired_q  <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      wr_addr       <= wr_addr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      pre_len_q     <= pre_len_nxt;
      post_len_q    <= post_len_nxt;
      trig_addr_q   <= trig_addr_nxt;
      mem_addr_q    <= mem_addr_nxt;
      enable_trig_q <= enable_trig_nxt;
      wr_en_q       <= wr_en_nxt;
      done_q        <= done_nxt;
`ifdef CAPTURE_AUTO_TRIG_EN
      auto_en_q     <= auto_en_nxt;
      auto_fired_q  <= auto_fired_nxt;
`endif
    end
  end

  assign bus.Enable_Trig  = enable_trig_q;
  assign bus.Wr_En        = wr_en_q;
  assign bus.Mem_Addr     = mem_addr_q;
  assign bus.Trig_Addr    = trig_addr_q;
  assign bus.Capture_Done = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Testbench for capture_ctrl with a 16-entry sample memory. The reference
// model counts written samples and derives every expected address, flag
// and read pointer from those counts.
module tb_capture_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  typedef logic [AW-1:0] addr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  capture_ctrl_if #(.ADDR_W(AW)) bus ();
  capture_ctrl #(.ADDR_W(AW)) dut (.CLK(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One capture from a Start pulse. en_mode: 0 strobe every cycle,
  // 4 strobe one cycle in four, otherwise random strobe.
  // stop_after >= 0 aborts once that many post samples are written;
  // restart_armed returns two cycles into the armed window.
  task automatic run_capture(input int pre, input int post, input int en_mode,
                             input int trig_delay, input int stop_after,
                             input bit restart_armed);
    int n_wr = 0;
    int n_before = 0;
    int post_seen = 0;
    int since_arm = 0;
    int cyc = 0;
    int trig_exp = 0;
    int rd_exp = 0;
    bit armed_m = 1'b0;
    bit trig_m = 1'b0;
    bit done_m = 1'b0;
    bit en, trg, rd;

    bus.Start    = 1'b1;
    bus.CLK_EN   = 1'b0;
    bus.Rd_Next  = 1'b0;
    bus.Trig_In  = 1'($urandom_range(0, 1));
    bus.Pre_Len  = addr_t'(pre);
    bus.Post_Len = addr_t'(post);
    tick();
    bus.Start    = 1'b0;
    // Lengths must already be latched; scramble the inputs.
    bus.Pre_Len  = addr_t'($urandom);
    bus.Post_Len = addr_t'($urandom);
    check("start_enable_trig", 32'(bus.Enable_Trig), 0);
    check("start_capture_done", 32'(bus.Capture_Done), 0);
    check("start_wr_en", 32'(bus.Wr_En), 0);

    while (!done_m && cyc < 600) begin
      case (en_mode)
        0:       en = 1'b1;
        4:       en = (cyc % 4 == 0);
        default: en = 1'($urandom_range(0, 1));
      endcase
      if (armed_m && !trig_m) trg = (since_arm >= trig_delay);
      else                    trg = 1'($urandom_range(0, 1));
      bus.CLK_EN  = en;
      bus.Trig_In = trg;

      n_before = n_wr;
      if (en) n_wr++;
      if (!armed_m) begin
        if (en && n_wr == pre + 1) armed_m = 1'b1;
      end else if (!trig_m) begin
        if (trg) begin
          trig_m   = 1'b1;
          trig_exp = n_before % DEPTH;
        end
        since_arm++;
      end else if (en) begin
        post_seen++;
        if (post_seen == post + 1) done_m = 1'b1;
      end

      tick();
      check("wr_en", 32'(bus.Wr_En), 32'(en));
      if (en) check("wr_addr", 32'(bus.Mem_Addr), n_before % DEPTH);
      check("enable_trig", 32'(bus.Enable_Trig), 32'(armed_m && !done_m));
      check("capture_done", 32'(bus.Capture_Done), 32'(done_m));
      if (trig_m) check("trig_addr", 32'(bus.Trig_Addr), trig_exp);
      cyc++;

      if (restart_armed && armed_m && !trig_m && since_arm == 2) return;

      if (stop_after >= 0 && trig_m && !done_m && post_seen == stop_after) begin
        bus.Stop    = 1'b1;
        bus.CLK_EN  = 1'b1;
        bus.Trig_In = 1'b1;
        tick();
        bus.Stop = 1'b0;
        check("stop_wr_en", 32'(bus.Wr_En), 0);
        check("stop_enable_trig", 32'(bus.Enable_Trig), 0);
        check("stop_capture_done", 32'(bus.Capture_Done), 0);
        check("stop_trig_addr_kept", 32'(bus.Trig_Addr), trig_exp);
        tick();
        check("idle_no_write", 32'(bus.Wr_En), 0);
        bus.Start = 1'b1;
        bus.Stop  = 1'b1;
        tick();
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        tick();
        check("start_stop_wr_en", 32'(bus.Wr_En), 0);
        check("start_stop_enable_trig", 32'(bus.Enable_Trig), 0);
        check("start_stop_capture_done", 32'(bus.Capture_Done), 0);
        bus.CLK_EN  = 1'b0;
        bus.Trig_In = 1'b0;
        return;
      end
    end

    if (!done_m) begin
      check("capture_timeout", 32'(bus.Capture_Done), 1);
      return;
    end

    // Readout: five Rd_Next pulses with noise on the trigger and strobe.
    rd_exp = ((trig_exp - pre) % DEPTH + DEPTH) % DEPTH;
    for (int k = 0; k < 10; k++) begin
      rd = (k % 2 == 0);
      bus.Rd_Next = rd;
      bus.Trig_In = 1'($urandom_range(0, 1));
      bus.CLK_EN  = 1'($urandom_range(0, 1));
      tick();
      rd_exp = (rd_exp + int'(rd)) % DEPTH;
      check("rd_addr", 32'(bus.Mem_Addr), rd_exp);
      check("done_wr_en", 32'(bus.Wr_En), 0);
      check("done_flag", 32'(bus.Capture_Done), 1);
      check("done_enable_trig", 32'(bus.Enable_Trig), 0);
    end
    bus.Rd_Next = 1'b0;
    bus.CLK_EN  = 1'b0;
    bus.Trig_In = 1'b0;
  endtask

  initial begin
    int mode_sel;
    bus.CLK_EN   = 1'b0;
    bus.Start    = 1'b0;
    bus.Stop     = 1'b0;
    bus.Pre_Len  = '0;
    bus.Post_Len = '0;
    bus.Trig_In  = 1'b0;
    bus.Rd_Next  = 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
    bus.Auto_Len = 16'd0;
`endif
    tick();
    tick();
    check("rst_enable_trig", 32'(bus.Enable_Trig), 0);
    check("rst_wr_en", 32'(bus.Wr_En), 0);
    check("rst_mem_addr", 32'(bus.Mem_Addr), 0);
    check("rst_trig_addr", 32'(bus.Trig_Addr), 0);
    check("rst_capture_done", 32'(bus.Capture_Done), 0);
    rst = 1'b0;
    tick();

    // Basic capture, trigger ten cycles after arming.
    run_capture(4, 3, 0, 10, -1, 1'b0);
    // Sparse strobe; trigger lands on a strobe-low cycle.
    run_capture(3, 5, 4, 2, -1, 1'b0);
    // Write pointer wrap, single post sample, read pointer wrap.
    run_capture(2, 0, 0, 17, -1, 1'b0);
    run_capture(2, 0, 0, 13, -1, 1'b0);
    // Minimum lengths.
    run_capture(0, 0, 0, 0, -1, 1'b0);
    // Abort in the middle of the post window, then Start+Stop together.
    run_capture(3, 6, 0, 3, 2, 1'b0);
    // Restart while armed.
    run_capture(1, 2, 0, 20, -1, 1'b1);
    run_capture(2, 2, 1, 4, -1, 1'b0);

    // Asynchronous reset in the armed window.
    run_capture(2, 2, 0, 20, -1, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_enable_trig", 32'(bus.Enable_Trig), 0);
    check("arst_wr_en", 32'(bus.Wr_En), 0);
    check("arst_mem_addr", 32'(bus.Mem_Addr), 0);
    check("arst_trig_addr", 32'(bus.Trig_Addr), 0);
    check("arst_capture_done", 32'(bus.Capture_Done), 0);
    bus.CLK_EN = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Randomized captures.
    for (int i = 0; i < 6; i++) begin
      mode_sel = $urandom_range(0, 2);
      run_capture($urandom_range(0, 6), $urandom_range(0, 6),
                  (mode_sel == 0) ? 0 : (mode_sel == 1) ? 4 : 1,
                  $urandom_range(0, 12), -1, 1'b0);
    end

`ifdef CAPTURE_AUTO_TRIG_EN
    // Auto trigger: eight strobes of timeout, fires on the ninth.
    bus.Auto_Len = 16'd8;
    bus.Trig_In  = 1'b0;
    bus.Pre_Len  = addr_t'(1);
    bus.Post_Len = addr_t'(1);
    bus.Start    = 1'b1;
    tick();
    bus.Start  = 1'b0;
    bus.CLK_EN = 1'b1;
    tick();
    tick();
    check("auto_armed", 32'(bus.Enable_Trig), 1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("auto_fired", 32'(bus.Auto_Fired), 32'(k == 9));
    end
    check("auto_trig_addr", 32'(bus.Trig_Addr), 10);
    bus.CLK_EN   = 1'b0;
    bus.Auto_Len = 16'd0;
    #3;
    rst = 1'b1;
    #1;
    check("auto_rst_fired", 32'(bus.Auto_Fired), 0);
    check("auto_rst_enable_trig", 32'(bus.Enable_Trig), 0);
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
